// File: rtl/instrument_pkg.sv
// Shared definitions for the string-instrument actuator path: sequencer states,
// fret width, default timing and the instrument ID codes used by the decoder.
package instrument_pkg;

  localparam int FRET_W = 5;

  // Defaults assume a 50 MHz clock: 5 ms settle, 10 ms strum, 5 ms re-arm.
  localparam int DEF_SETTLE_CYCLES = 250000;
  localparam int DEF_STRUM_CYCLES  = 500000;
  localparam int DEF_REARM_CYCLES  = 250000;

  typedef enum logic [7:0] {
    INSTR_GUITAR = 8'h01,
    INSTR_BASS   = 8'h02
  } instrument_id_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_STRUM,
    ST_REARM
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fret_strum_sequencer.sv
// Turns fret-pattern note events into fret press, settle, strum pulse and
// re-arm timing; one event may be held pending while a note is in flight.
module fret_strum_sequencer
  import instrument_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int STRUM_CYCLES  = DEF_STRUM_CYCLES,
  parameter int REARM_CYCLES  = DEF_REARM_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FRET_W-1:0] frets_in,
  input  logic              frets_valid,
  output logic [FRET_W-1:0] frets_out,
  output logic              strum,
  output logic              busy,
  output logic              dropped
);

  localparam int CNT_W = $clog2(max3(SETTLE_CYCLES, STRUM_CYCLES, REARM_CYCLES) + 1);

  // Each phase counts down from N-1 so the exit edge is exactly N edges after entry.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STRUM_LOAD  = CNT_W'(STRUM_CYCLES - 1);
  localparam logic [CNT_W-1:0] REARM_LOAD  = CNT_W'(REARM_CYCLES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [FRET_W-1:0]  frets_q;
  logic               strum_q;
  logic               busy_q;
  logic               dropped_q;
  logic               pend_valid_q;
  logic [FRET_W-1:0]  pend_data_q;

  logic               cnt_done;
  logic               rearm_exit;
  logic               capture;
  logic               next_avail;
  logic [FRET_W-1:0]  next_data;

  assign cnt_done   = (cnt_q == '0);
  assign rearm_exit = (state_q == ST_REARM) && cnt_done;
  assign capture    = frets_valid && (state_q != ST_IDLE) && !rearm_exit;
  // An event arriving on the re-arm exit edge supersedes the pending one.
  assign next_avail = frets_valid || pend_valid_q;
  assign next_data  = frets_valid ? frets_in : pend_data_q;

  // NOTE: every register here, pending data included, is cleared by the async
  // reset so a mid-note reset releases all solenoids without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      frets_q      <= '0;
      strum_q      <= 1'b0;
      busy_q       <= 1'b0;
      dropped_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in this
      // block override the defaults above them within the same edge.
      dropped_q <= 1'b0;

      if (capture) begin
        pend_data_q  <= frets_in;
        pend_valid_q <= 1'b1;
        dropped_q    <= pend_valid_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (frets_valid) begin
            frets_q <= frets_in;
            if (|frets_in) begin
              state_q <= ST_SETTLE;
              cnt_q   <= SETTLE_LOAD;
              busy_q  <= 1'b1;
            end
          end
        end

        ST_SETTLE: begin
          if (cnt_done) begin
            state_q <= ST_STRUM;
            cnt_q   <= STRUM_LOAD;
            strum_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_STRUM: begin
          if (cnt_done) begin
            state_q <= ST_REARM;
            cnt_q   <= REARM_LOAD;
            strum_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_REARM: begin
          if (cnt_done) begin
            pend_valid_q <= 1'b0;
            dropped_q    <= frets_valid && pend_valid_q;
            if (next_avail) begin
              frets_q <= next_data;
            end
            if (next_avail && (|next_data)) begin
              state_q <= ST_SETTLE;
              cnt_q   <= SETTLE_LOAD;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          strum_q <= 1'b0;
        end
      endcase
    end
  end

  assign frets_out = frets_q;
  assign strum     = strum_q;
  assign busy      = busy_q;
  assign dropped   = dropped_q;

endmodule
